// File: rtl/gpio_port_pkg.sv
// Shared opcodes, FSM states and constants for the GPIO port responder.
package gpio_port_pkg;

    typedef enum logic [3:0] {
        OP_WRITE_OUT = 4'h1,
        OP_WRITE_DIR = 4'h2,
        OP_SET       = 4'h3,
        OP_CLR       = 4'h4,
        OP_TGL       = 4'h5,
        OP_READ_PINS = 4'h8,
        OP_READ_OUT  = 4'h9,
        OP_READ_DIR  = 4'hA,
        OP_WAIT_EDGE = 4'hC
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [12:0] CLKCMD_PATTERN = 13'h1C00;
    localparam logic [7:0]  TIMEOUT_FLAG   = 8'h80;
    localparam logic [15:0] UNKNOWN_DATA   = 16'hFFFF;

endpackage

// File: rtl/gpio_port_responder_pin_sync_edge.sv
// Two-flop pin synchronizer plus a snapshot/mask pair used to detect masked
// changes on the synchronized pins while a wait-for-edge is pending.
module pin_sync_edge
    import gpio_port_pkg::*;
#(
    parameter int PINCOUNT = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clk_en,
    input  logic                i_capture,
    input  logic [PINCOUNT-1:0] i_pins,
    input  logic [PINCOUNT-1:0] i_mask,
    output logic [PINCOUNT-1:0] o_synced,
    output logic                o_changed
);

    logic [PINCOUNT-1:0] r_meta;
    logic [PINCOUNT-1:0] r_sync;
    logic [PINCOUNT-1:0] r_snap;
    logic [PINCOUNT-1:0] r_mask;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
            r_snap <= '0;
            r_mask <= '0;
        end else if (i_clk_en) begin
            r_meta <= i_pins;
            r_sync <= r_meta;
            // Snapshot is the synced value seen in the accept cycle.
            if (i_capture) begin
                r_snap <= r_sync;
                r_mask <= i_mask;
            end
        end
    end

    assign o_synced  = r_sync;
    assign o_changed = |((r_sync ^ r_snap) & r_mask);

endmodule

// File: rtl/gpio_port_responder.sv
// Device-side responder for one IO port command bundle: decodes command words,
// drives a small GPIO block and returns register/memory responses.
module gpio_port_responder
    import gpio_port_pkg::*;
#(
    parameter int          PINCOUNT      = 8,
    parameter logic [7:0]  RESETOUT      = 8'h00,
    parameter logic [15:0] TIMEOUTCYCLES = 16'd0
) (
    input  logic                sys_clk,
    input  logic                async_rst,
    input  logic                clk_en,
    input  logic                CmdEn,
    output logic                CmdReady,
    input  logic                CmdResponseRequested,
    input  logic [3:0]          CmdDestReg,
    input  logic [15:0]         CmdData,
    output logic                RespACK,
    input  logic                RespREQ,
    output logic                RespRegFlag,
    output logic                RespMemFlag,
    output logic [3:0]          RespDestReg,
    output logic [15:0]         RespData,
    input  logic [PINCOUNT-1:0] PinsIn,
    output logic [PINCOUNT-1:0] PinsOut,
    output logic [PINCOUNT-1:0] PinsOE,
    output logic [1:0]          DbgState
);

    // Handshakes: a command transfers on a rising edge with CmdEn && CmdReady
    // (and clk_en); a response transfers on a rising edge with RespACK && RespREQ
    // (and clk_en), and RespACK plus every Resp* field stay stable until then.

    state_e              r_state;
    state_e              w_next;
    logic [PINCOUNT-1:0] r_out;
    logic [PINCOUNT-1:0] r_oe;
    logic [15:0]         r_cnt;
    logic [3:0]          r_tag;
    logic                r_ack;
    logic                r_reg;
    logic                r_mem;
    logic [3:0]          r_dest;
    logic [15:0]         r_data;

    logic [3:0]          w_op;
    logic [7:0]          w_arg8;
    logic [PINCOUNT-1:0] w_arg;
    logic                w_cmd;
    logic                w_timeout;
    logic                w_resp_done;
    logic [PINCOUNT-1:0] w_synced;
    logic                w_changed;
    logic [PINCOUNT-1:0] w_out_nxt;
    logic [PINCOUNT-1:0] w_oe_nxt;
    logic                w_capture;
    logic                w_resp_load;
    logic                w_resp_reg;
    logic                w_resp_mem;
    logic [3:0]          w_resp_dest;
    logic [15:0]         w_resp_data;
    logic                w_unused;

    assign CmdReady = (r_state == ST_IDLE) && clk_en;
    assign w_op     = CmdData[15:12];
    assign w_arg8   = CmdData[7:0];
    assign w_arg    = w_arg8[PINCOUNT-1:0];
    assign w_unused = ^CmdData[11:8];

    // Clock-control words share this bus and are swallowed without effect.
    assign w_cmd       = CmdEn && CmdReady && (CmdData[12:0] != CLKCMD_PATTERN);
    assign w_timeout   = (TIMEOUTCYCLES != 16'd0) && ((r_cnt + 16'd1) == TIMEOUTCYCLES);
    assign w_resp_done = (r_state == ST_RESP) && RespREQ;

    pin_sync_edge #(.PINCOUNT(PINCOUNT)) u_sync (
        .i_clk     (sys_clk),
        .i_rst     (async_rst),
        .i_clk_en  (clk_en),
        .i_capture (w_capture),
        .i_pins    (PinsIn),
        .i_mask    (w_arg),
        .o_synced  (w_synced),
        .o_changed (w_changed)
    );

    always_comb begin
        w_next      = r_state;
        w_out_nxt   = r_out;
        w_oe_nxt    = r_oe;
        w_capture   = 1'b0;
        w_resp_load = 1'b0;
        w_resp_reg  = 1'b0;
        w_resp_mem  = 1'b0;
        w_resp_dest = CmdDestReg;
        w_resp_data = 16'h0000;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd) begin
                    case (w_op)
                        OP_WRITE_OUT, OP_SET, OP_CLR, OP_TGL: begin
                            w_resp_load = CmdResponseRequested;
                            w_resp_mem  = 1'b1;
                            w_resp_data = 16'(r_out);
                            if (w_op == OP_WRITE_OUT)  w_out_nxt = w_arg;
                            else if (w_op == OP_SET)   w_out_nxt = r_out | w_arg;
                            else if (w_op == OP_CLR)   w_out_nxt = r_out & ~w_arg;
                            else                       w_out_nxt = r_out ^ w_arg;
                        end
                        OP_WRITE_DIR: begin
                            w_resp_load = CmdResponseRequested;
                            w_resp_mem  = 1'b1;
                            w_resp_data = 16'(r_oe);
                            w_oe_nxt    = w_arg;
                        end
                        OP_READ_PINS, OP_READ_OUT, OP_READ_DIR: begin
                            w_resp_load = 1'b1;
                            w_resp_reg  = 1'b1;
                            if (w_op == OP_READ_PINS)     w_resp_data = 16'(w_synced);
                            else if (w_op == OP_READ_OUT) w_resp_data = 16'(r_out);
                            else                          w_resp_data = 16'(r_oe);
                        end
                        OP_WAIT_EDGE: begin
                            w_capture = 1'b1;
                            w_next    = ST_WAIT;
                        end
                        default: begin
                            w_resp_load = CmdResponseRequested;
                            w_resp_mem  = 1'b1;
                            w_resp_data = UNKNOWN_DATA;
                        end
                    endcase
                    if (w_resp_load) w_next = ST_RESP;
                end
            end
            ST_WAIT: begin
                w_resp_dest = r_tag;
                w_resp_reg  = 1'b1;
                // An edge seen in the same cycle as the timeout wins.
                if (w_changed) begin
                    w_resp_load = 1'b1;
                    w_resp_data = {8'h00, 8'(w_synced)};
                    w_next      = ST_RESP;
                end else if (w_timeout) begin
                    w_resp_load = 1'b1;
                    w_resp_data = {TIMEOUT_FLAG, 8'(w_synced)};
                    w_next      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (RespREQ) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) r_state <= ST_IDLE;
        else if (clk_en) r_state <= w_next;
    end

    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            r_out  <= RESETOUT[PINCOUNT-1:0];
            r_oe   <= '0;
            r_cnt  <= '0;
            r_tag  <= '0;
            r_ack  <= 1'b0;
            r_reg  <= 1'b0;
            r_mem  <= 1'b0;
            r_dest <= '0;
            r_data <= '0;
        end else if (clk_en) begin
            r_out <= w_out_nxt;
            r_oe  <= w_oe_nxt;
            if (w_capture) begin
                r_tag <= CmdDestReg;
                r_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_resp_load) begin
                r_ack  <= 1'b1;
                r_reg  <= w_resp_reg;
                r_mem  <= w_resp_mem;
                r_dest <= w_resp_dest;
                r_data <= w_resp_data;
            end else if (w_resp_done) begin
                r_ack <= 1'b0;
            end
        end
    end

    assign RespACK     = r_ack;
    assign RespRegFlag = r_reg;
    assign RespMemFlag = r_mem;
    assign RespDestReg = r_dest;
    assign RespData    = r_data;
    assign PinsOut     = r_out;
    assign PinsOE      = r_oe;
    assign DbgState    = r_state;

endmodule

// File: tb/tb_gpio_port_responder.sv
// Directed bench for gpio_port_responder: one instance without timeout, one
// with a 10-cycle wait-edge timeout, sharing clock and command bus.
module tb_gpio_port_responder;

    logic        sys_clk = 1'b0;
    logic        async_rst = 1'b1;
    logic        clk_en = 1'b1;
    logic        cmd_en0 = 1'b0;
    logic        cmd_en1 = 1'b0;
    logic        cmd_resp_req = 1'b0;
    logic [3:0]  cmd_dest = 4'h0;
    logic [15:0] cmd_data = 16'h0000;
    logic        resp_req = 1'b0;
    logic [7:0]  pins_in = 8'h00;

    logic        rdy0, ack0, regf0, memf0;
    logic [3:0]  dest0;
    logic [15:0] data0;
    logic [7:0]  pout0, poe0;
    logic [1:0]  dbg0;
    logic        rdy1, ack1, regf1, memf1;
    logic [3:0]  dest1;
    logic [15:0] data1;
    logic [7:0]  pout1, poe1;
    logic [1:0]  dbg1;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    gpio_port_responder #(.PINCOUNT(8), .RESETOUT(8'hA5), .TIMEOUTCYCLES(16'd0)) u_dut0 (
        .sys_clk(sys_clk), .async_rst(async_rst), .clk_en(clk_en),
        .CmdEn(cmd_en0), .CmdReady(rdy0), .CmdResponseRequested(cmd_resp_req),
        .CmdDestReg(cmd_dest), .CmdData(cmd_data),
        .RespACK(ack0), .RespREQ(resp_req), .RespRegFlag(regf0), .RespMemFlag(memf0),
        .RespDestReg(dest0), .RespData(data0),
        .PinsIn(pins_in), .PinsOut(pout0), .PinsOE(poe0), .DbgState(dbg0)
    );

    gpio_port_responder #(.PINCOUNT(8), .RESETOUT(8'hA5), .TIMEOUTCYCLES(16'd10)) u_dut1 (
        .sys_clk(sys_clk), .async_rst(async_rst), .clk_en(clk_en),
        .CmdEn(cmd_en1), .CmdReady(rdy1), .CmdResponseRequested(cmd_resp_req),
        .CmdDestReg(cmd_dest), .CmdData(cmd_data),
        .RespACK(ack1), .RespREQ(resp_req), .RespRegFlag(regf1), .RespMemFlag(memf1),
        .RespDestReg(dest1), .RespData(data1),
        .PinsIn(pins_in), .PinsOut(pout1), .PinsOE(poe1), .DbgState(dbg1)
    );

    // Called at a negedge; returns at the negedge of the cycle after accept.
    task automatic send0(input logic [15:0] d, input logic [3:0] t, input logic rr);
        cmd_data = d; cmd_dest = t; cmd_resp_req = rr; cmd_en0 = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_en0 = 1'b0; cmd_resp_req = 1'b0;
    endtask

    task automatic finish_resp;
        resp_req = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        resp_req = 1'b0;
    endtask

    task automatic test_reset;
        async_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        async_rst = 1'b0;
        @(negedge sys_clk);
        checks++; if (pout0 !== 8'hA5) begin errors++; $display("FAIL reset_pinsout: got %h expected a5", pout0); end
        checks++; if (poe0 !== 8'h00) begin errors++; $display("FAIL reset_pinsoe: got %h expected 00", poe0); end
        checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b/%b expected 0/0", ack0, ack1); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy0); end
        checks++; if (data0 !== 16'h0000 || dest0 !== 4'h0 || regf0 !== 1'b0 || memf0 !== 1'b0) begin
            errors++; $display("FAIL reset_resp_fields: got data %h dest %h reg %b mem %b expected all 0", data0, dest0, regf0, memf0);
        end
        checks++; if (dbg0 !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg0); end
    endtask

    task automatic test_write_out;
        resp_req = 1'b0;
        send0(16'h103C, 4'h7, 1'b1);
        checks++; if (pout0 !== 8'h3C) begin errors++; $display("FAIL wr_out_pins: got %h expected 3c", pout0); end
        checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL wr_out_ack: got %b expected 1", ack0); end
        checks++; if (data0 !== 16'h00A5 || memf0 !== 1'b1 || regf0 !== 1'b0 || dest0 !== 4'h7) begin
            errors++; $display("FAIL wr_out_resp: got data %h mem %b reg %b dest %h expected 00a5 1 0 7", data0, memf0, regf0, dest0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            checks++; if (ack0 !== 1'b1 || data0 !== 16'h00A5 || dest0 !== 4'h7 || rdy0 !== 1'b0) begin
                errors++; $display("FAIL wr_out_hold%0d: got ack %b data %h dest %h rdy %b expected 1 00a5 7 0", i, ack0, data0, dest0, rdy0);
            end
        end
        finish_resp();
        checks++; if (ack0 !== 1'b0 || rdy0 !== 1'b1) begin
            errors++; $display("FAIL wr_out_done: got ack %b rdy %b expected 0 1", ack0, rdy0);
        end
    endtask

    task automatic test_set_clr_tgl;
        send0(16'h300F, 4'h1, 1'b0);
        checks++; if (pout0 !== 8'h3F || ack0 !== 1'b0) begin errors++; $display("FAIL set: got pins %h ack %b expected 3f 0", pout0, ack0); end
        send0(16'h4003, 4'h1, 1'b0);
        checks++; if (pout0 !== 8'h3C || ack0 !== 1'b0) begin errors++; $display("FAIL clr: got pins %h ack %b expected 3c 0", pout0, ack0); end
        send0(16'h50FF, 4'h1, 1'b0);
        checks++; if (pout0 !== 8'hC3 || ack0 !== 1'b0) begin errors++; $display("FAIL tgl: got pins %h ack %b expected c3 0", pout0, ack0); end
    endtask

    task automatic test_dir_and_reads;
        send0(16'h20F0, 4'h2, 1'b1);
        checks++; if (poe0 !== 8'hF0 || ack0 !== 1'b1 || data0 !== 16'h0000 || memf0 !== 1'b1) begin
            errors++; $display("FAIL wr_dir: got oe %h ack %b data %h mem %b expected f0 1 0000 1", poe0, ack0, data0, memf0);
        end
        finish_resp();
        send0(16'hA000, 4'h3, 1'b0);
        checks++; if (ack0 !== 1'b1 || data0 !== 16'h00F0 || regf0 !== 1'b1 || memf0 !== 1'b0 || dest0 !== 4'h3) begin
            errors++; $display("FAIL rd_dir: got ack %b data %h reg %b mem %b dest %h expected 1 00f0 1 0 3", ack0, data0, regf0, memf0, dest0);
        end
        finish_resp();
        send0(16'h9000, 4'h4, 1'b0);
        checks++; if (ack0 !== 1'b1 || data0 !== 16'h00C3 || regf0 !== 1'b1) begin
            errors++; $display("FAIL rd_out: got ack %b data %h reg %b expected 1 00c3 1", ack0, data0, regf0);
        end
        finish_resp();
    endtask

    task automatic test_read_pins;
        pins_in = 8'h5A;
        repeat (3) @(negedge sys_clk);
        send0(16'h8000, 4'h5, 1'b0);
        checks++; if (ack0 !== 1'b1 || data0 !== 16'h005A || regf0 !== 1'b1 || memf0 !== 1'b0 || dest0 !== 4'h5) begin
            errors++; $display("FAIL rd_pins: got ack %b data %h reg %b mem %b dest %h expected 1 005a 1 0 5", ack0, data0, regf0, memf0, dest0);
        end
        finish_resp();
    endtask

    task automatic test_unknown_and_clkcmd;
        send0(16'h7012, 4'h6, 1'b1);
        checks++; if (ack0 !== 1'b1 || data0 !== 16'hFFFF || memf0 !== 1'b1 || regf0 !== 1'b0 || dest0 !== 4'h6) begin
            errors++; $display("FAIL unknown_req: got ack %b data %h mem %b reg %b dest %h expected 1 ffff 1 0 6", ack0, data0, memf0, regf0, dest0);
        end
        finish_resp();
        send0(16'h7012, 4'h6, 1'b0);
        checks++; if (ack0 !== 1'b0 || rdy0 !== 1'b1 || pout0 !== 8'hC3) begin
            errors++; $display("FAIL unknown_noreq: got ack %b rdy %b pins %h expected 0 1 c3", ack0, rdy0, pout0);
        end
        send0(16'h3C00, 4'h8, 1'b1);
        checks++; if (ack0 !== 1'b0 || rdy0 !== 1'b1 || pout0 !== 8'hC3 || dbg0 !== 2'd0) begin
            errors++; $display("FAIL clkcmd: got ack %b rdy %b pins %h state %0d expected 0 1 c3 0", ack0, rdy0, pout0, dbg0);
        end
    endtask

    task automatic test_clk_en;
        clk_en = 1'b0;
        #1;
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL clken_ready: got %b expected 0", rdy0); end
        clk_en = 1'b1;
        send0(16'h9000, 4'hB, 1'b0);
        clk_en = 1'b0;
        resp_req = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++; if (ack0 !== 1'b1 || data0 !== 16'h00C3 || dbg0 !== 2'd2) begin
            errors++; $display("FAIL clken_freeze: got ack %b data %h state %0d expected 1 00c3 2", ack0, data0, dbg0);
        end
        clk_en = 1'b1;
        @(negedge sys_clk);
        resp_req = 1'b0;
        checks++; if (ack0 !== 1'b0 || rdy0 !== 1'b1) begin
            errors++; $display("FAIL clken_resume: got ack %b rdy %b expected 0 1", ack0, rdy0);
        end
    endtask

    task automatic test_wait_edge;
        send0(16'hC001, 4'h9, 1'b0);
        checks++; if (ack0 !== 1'b0 || dbg0 !== 2'd1 || rdy0 !== 1'b0) begin
            errors++; $display("FAIL wait_enter: got ack %b state %0d rdy %b expected 0 1 0", ack0, dbg0, rdy0);
        end
        pins_in = 8'h58;
        repeat (5) @(negedge sys_clk);
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL wait_unmasked: got ack %b expected 0", ack0); end
        pins_in = 8'h59;
        @(negedge sys_clk);
        @(negedge sys_clk);
        checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL wait_early: got ack %b expected 0", ack0); end
        @(negedge sys_clk);
        checks++; if (ack0 !== 1'b1 || data0 !== 16'h0059 || regf0 !== 1'b1 || memf0 !== 1'b0 || dest0 !== 4'h9) begin
            errors++; $display("FAIL wait_edge: got ack %b data %h reg %b mem %b dest %h expected 1 0059 1 0 9", ack0, data0, regf0, memf0, dest0);
        end
        finish_resp();
    endtask

    task automatic test_timeout;
        cmd_data = 16'hC0FF; cmd_dest = 4'h4; cmd_en1 = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_en1 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            checks++; if (ack1 !== 1'b0) begin errors++; $display("FAIL timeout_early_n%0d: got ack %b expected 0", k, ack1); end
            @(negedge sys_clk);
        end
        checks++; if (ack1 !== 1'b1 || data1 !== 16'h8059 || regf1 !== 1'b1 || dest1 !== 4'h4) begin
            errors++; $display("FAIL timeout_resp: got ack %b data %h reg %b dest %h expected 1 8059 1 4", ack1, data1, regf1, dest1);
        end
        finish_resp();
        checks++; if (ack1 !== 1'b0 || rdy1 !== 1'b1) begin
            errors++; $display("FAIL timeout_done: got ack %b rdy %b expected 0 1", ack1, rdy1);
        end
    endtask

    task automatic test_reset_mid_wait;
        send0(16'hC000, 4'h1, 1'b0);
        pins_in = 8'hFF;
        repeat (4) @(negedge sys_clk);
        checks++; if (ack0 !== 1'b0 || dbg0 !== 2'd1) begin
            errors++; $display("FAIL zero_mask_wait: got ack %b state %0d expected 0 1", ack0, dbg0);
        end
        async_rst = 1'b1;
        #1;
        checks++; if (ack0 !== 1'b0 || dbg0 !== 2'd0 || pout0 !== 8'hA5 || poe0 !== 8'h00) begin
            errors++; $display("FAIL rst_abort: got ack %b state %0d pins %h oe %h expected 0 0 a5 00", ack0, dbg0, pout0, poe0);
        end
        @(negedge sys_clk);
        async_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++; if (ack0 !== 1'b0 || rdy0 !== 1'b1) begin
            errors++; $display("FAIL rst_idle: got ack %b rdy %b expected 0 1", ack0, rdy0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_out();
        test_set_clr_tgl();
        test_dir_and_reads();
        test_read_pins();
        test_unknown_and_clkcmd();
        test_clk_en();
        test_wait_edge();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
